// File: rtl/bcp_pkg.sv
// bcp_pkg: shared types, defaults and literal helpers for the BCP clause evaluator.
package bcp_pkg;

    localparam int BCP_NUM_VARS = 64;
    localparam int BCP_VAR_W    = 6;

    typedef struct packed {
        logic       valid;
        logic       neg;
        logic [5:0] idx;
    } lit_t;

    typedef enum logic [1:0] {
        ASG_U = 2'b00,
        ASG_F = 2'b01,
        ASG_T = 2'b10
    } asg_e;

    typedef enum logic [1:0] {
        RES_SAT      = 2'b00,
        RES_UNIT     = 2'b01,
        RES_CONFLICT = 2'b10,
        RES_UNRES    = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        EVAL,
        RESULT
    } state_e;

    function automatic logic lit_true(input lit_t l, input logic [1:0] v);
        return l.valid & ((v == ASG_T && !l.neg) || (v == ASG_F && l.neg));
    endfunction

    function automatic logic lit_false(input lit_t l, input logic [1:0] v);
        return l.valid & ((v == ASG_F && !l.neg) || (v == ASG_T && l.neg));
    endfunction

endpackage

// File: rtl/bcp_assign_table.sv
// bcp_assign_table: 2-bit-per-variable assignment table with clear, host and imply
// write ports (clear > host > imply) and four combinational read ports.
module bcp_assign_table
    import bcp_pkg::*;
#(
    parameter int NUM_VARS = BCP_NUM_VARS,
    parameter int VAR_W    = BCP_VAR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  host_en,
    input  logic [VAR_W-1:0]      host_var,
    input  logic [1:0]            host_val,
    input  logic                  imp_en,
    input  logic [VAR_W-1:0]      imp_var,
    input  logic [1:0]            imp_val,
    input  logic [3:0][VAR_W-1:0] rd_var,
    output logic [3:0][1:0]       rd_val
);

    logic [1:0] tab [NUM_VARS];

    // A host value of 11 is a no-op, so it does not shadow a same-cycle imply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VARS; i++) tab[i] <= ASG_U;
        end else begin
            for (int i = 0; i < NUM_VARS; i++) begin
                if (clear)
                    tab[i] <= ASG_U;
                else if (host_en && host_val != 2'b11 && int'(host_var) == i)
                    tab[i] <= host_val;
                else if (imp_en && int'(imp_var) == i)
                    tab[i] <= imp_val;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++)
            rd_val[r] = (int'(rd_var[r]) < NUM_VARS) ? tab[rd_var[r]] : ASG_U;
    end

endmodule

// File: rtl/bcp_clause_eval.sv
// bcp_clause_eval: accepts a packed 4-literal clause, looks up its variables and
// classifies it as SAT/UNIT/CONFLICT/UNRESOLVED, optionally applying unit implications.
module bcp_clause_eval
    import bcp_pkg::*;
#(
    parameter int NUM_VARS = BCP_NUM_VARS,
    parameter int VAR_W    = BCP_VAR_W
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             asg_wr_en,
    input  logic [VAR_W-1:0] asg_wr_var,
    input  logic [1:0]       asg_wr_val,
    input  logic             asg_clear,
    input  logic             auto_imply,
    input  logic             clause_valid,
    output logic             clause_ready,
    input  logic [31:0]      clause_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_status,
    output logic [7:0]       res_lit,
    output logic [15:0]      imply_cnt,
    output logic             conflict,
    output logic             busy
);

    state_e                 state;
    logic [31:0]            clause_q;
    logic [3:0][1:0]        vals_q;
    lit_t [3:0]             lits;
    logic [3:0][VAR_W-1:0]  rd_var;
    logic [3:0][1:0]        rd_val;
    logic                   any_t;
    logic [2:0]             ucnt;
    lit_t                   unit_lit;
    status_e                status;
    logic                   imp_en;

    assign lits = clause_q;

    always_comb begin
        for (int i = 0; i < 4; i++) rd_var[i] = VAR_W'(lits[i].idx);
    end

    // Duplicate unassigned slots each count, so a repeated literal is never UNIT.
    always_comb begin
        any_t    = 1'b0;
        ucnt     = '0;
        unit_lit = '0;
        for (int i = 0; i < 4; i++) begin
            if (lit_true(lits[i], vals_q[i])) begin
                any_t = 1'b1;
            end else if (lits[i].valid && !lit_false(lits[i], vals_q[i])) begin
                ucnt     = ucnt + 3'd1;
                unit_lit = lits[i];
            end
        end
        status = any_t ? RES_SAT : (ucnt == 3'd0) ? RES_CONFLICT :
                 (ucnt == 3'd1) ? RES_UNIT : RES_UNRES;
    end

    assign imp_en = (state == EVAL) && (status == RES_UNIT) && auto_imply;

    bcp_assign_table #(
        .NUM_VARS(NUM_VARS),
        .VAR_W   (VAR_W)
    ) u_tab (
        .clk     (ACLK),
        .rst     (ARESET),
        .clear   (asg_clear),
        .host_en (asg_wr_en),
        .host_var(asg_wr_var),
        .host_val(asg_wr_val),
        .imp_en  (imp_en),
        .imp_var (VAR_W'(unit_lit.idx)),
        .imp_val (unit_lit.neg ? ASG_F : ASG_T),
        .rd_var  (rd_var),
        .rd_val  (rd_val)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state        <= IDLE;
            clause_q     <= '0;
            vals_q       <= '0;
            clause_ready <= 1'b1;
            res_valid    <= 1'b0;
            res_status   <= RES_SAT;
            res_lit      <= '0;
            imply_cnt    <= '0;
            conflict     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (asg_clear)
                conflict <= 1'b0;
            else if (state == EVAL && status == RES_CONFLICT)
                conflict <= 1'b1;
            case (state)
                IDLE: if (clause_valid) begin
                    clause_q     <= clause_data;
                    clause_ready <= 1'b0;
                    busy         <= 1'b1;
                    state        <= LOOKUP;
                end
                LOOKUP: begin
                    vals_q <= rd_val;
                    state  <= EVAL;
                end
                EVAL: begin
                    res_status <= status;
                    res_lit    <= (status == RES_UNIT) ? unit_lit : 8'h00;
                    res_valid  <= 1'b1;
                    if (status == RES_UNIT && imply_cnt != 16'hFFFF)
                        imply_cnt <= imply_cnt + 16'd1;
                    state <= RESULT;
                end
                RESULT: if (res_ready) begin
                    res_valid    <= 1'b0;
                    clause_ready <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
